// File: rtl/cbfp_block_ctrl.sv
// Block-floating-point controller: captures complex samples into a ping-pong buffer,
// tracks each block's largest magnitude index and drains it with one common arithmetic shift.
module cbfp_block_ctrl #(
  parameter int IN_W    = 25,
  parameter int OUT_W   = 13,
  parameter int BLK_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [IN_W-1:0]       din_re,
  input  logic [IN_W-1:0]       din_im,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [OUT_W-1:0]      dout_re,
  output logic [OUT_W-1:0]      dout_im,
  output logic                  dout_last,
  output logic [$clog2(IN_W):0] dout_exp
);

  localparam int EXP_W = $clog2(IN_W) + 1;
  localparam int PTR_W = $clog2(BLK_LEN);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BLK_LEN - 1);

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILLING,
    B_FULL,
    B_DRAINING
  } bank_state_e;

  typedef enum logic {
    R_IDLE,
    R_DRAIN
  } rd_state_e;

  // Folding negative values onto their complement turns "highest 0 below the sign"
  // into "highest 1", and maps both 0 and -1 to index 0.
  function automatic logic [EXP_W-1:0] mag_index(input logic [IN_W-1:0] x);
    logic [IN_W-2:0] y;
    mag_index = '0;
    y = x[IN_W-2:0] ^ {(IN_W-1){x[IN_W-1]}};
    for (int i = 0; i < IN_W - 1; i++) begin
      if (y[i]) mag_index = EXP_W'(i);
    end
  endfunction

  function automatic logic [EXP_W-1:0] max_k(input logic [EXP_W-1:0] a,
                                             input logic [EXP_W-1:0] b);
    max_k = (a > b) ? a : b;
  endfunction

  function automatic logic [EXP_W-1:0] shift_of(input logic [EXP_W-1:0] k);
    int s;
    s = int'(k) + 2 - OUT_W;
    shift_of = (s > 0) ? EXP_W'(s) : '0;
  endfunction

  logic [IN_W-1:0]  mem_re_q [2][BLK_LEN];
  logic [IN_W-1:0]  mem_im_q [2][BLK_LEN];

  bank_state_e      bank_st_q [2];
  bank_state_e      bank_st_d [2];
  logic [EXP_W-1:0] kmax_q    [2];
  logic [EXP_W-1:0] kmax_d    [2];
  logic [EXP_W-1:0] shift_q   [2];
  logic [EXP_W-1:0] shift_d   [2];

  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic             other_rbank;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  rd_state_e        rd_st_q, rd_st_d;

  logic             din_ready_q, din_ready_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_last_q, dout_last_d;
  logic [OUT_W-1:0] dout_re_q, dout_re_d;
  logic [OUT_W-1:0] dout_im_q, dout_im_d;
  logic [EXP_W-1:0] dout_exp_q, dout_exp_d;

  logic             wr_fire;
  logic             out_free;
  logic [EXP_W-1:0] din_k;
  logic [EXP_W-1:0] blk_k;
  logic signed [IN_W-1:0] rd_re, rd_im;

  assign wr_fire     = din_valid && din_ready_q;
  assign out_free    = !dout_valid_q || dout_ready;
  assign other_rbank = ~rbank_q;
  assign din_k       = max_k(mag_index(din_re), mag_index(din_im));
  assign blk_k       = (wptr_q == '0) ? din_k : max_k(kmax_q[wbank_q], din_k);
  assign rd_re       = $signed(mem_re_q[rbank_q][rptr_q]);
  assign rd_im       = $signed(mem_im_q[rbank_q][rptr_q]);

  // Write side, read side and the output skid register share the bank states, so they
  // are resolved together: write effects first, then the read side may override them.
  always_comb begin
    bank_st_d    = bank_st_q;
    kmax_d       = kmax_q;
    shift_d      = shift_q;
    wbank_d      = wbank_q;
    wptr_d       = wptr_q;
    rbank_d      = rbank_q;
    rptr_d       = rptr_q;
    rd_st_d      = rd_st_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    dout_re_d    = dout_re_q;
    dout_im_d    = dout_im_q;
    dout_exp_d   = dout_exp_q;

    if (wr_fire) begin
      kmax_d[wbank_q] = blk_k;
      if (wptr_q == LAST_PTR) begin
        bank_st_d[wbank_q] = B_FULL;
        shift_d[wbank_q]   = shift_of(blk_k);
        wptr_d             = '0;
        wbank_d            = ~wbank_q;
      end else begin
        wptr_d = wptr_q + 1'b1;
        if (bank_st_q[wbank_q] == B_EMPTY) bank_st_d[wbank_q] = B_FILLING;
      end
    end

    if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;

    case (rd_st_q)
      R_IDLE: begin
        if (bank_st_q[rbank_q] == B_FULL) begin
          bank_st_d[rbank_q] = B_DRAINING;
          rptr_d             = '0;
          rd_st_d            = R_DRAIN;
        end
      end
      R_DRAIN: begin
        if (out_free) begin
          dout_valid_d = 1'b1;
          dout_re_d    = OUT_W'(rd_re >>> shift_q[rbank_q]);
          dout_im_d    = OUT_W'(rd_im >>> shift_q[rbank_q]);
          dout_exp_d   = shift_q[rbank_q];
          dout_last_d  = (rptr_q == LAST_PTR);
          rptr_d       = rptr_q + 1'b1;
          // The bank is released once its last sample sits in the output register;
          // the write side may already have started refilling its fetched slots.
          if (rptr_q == LAST_PTR) begin
            bank_st_d[rbank_q] = (wbank_d == rbank_q && wptr_d != '0) ? B_FILLING : B_EMPTY;
            rbank_d            = other_rbank;
            if (bank_st_q[other_rbank] == B_FULL) begin
              bank_st_d[other_rbank] = B_DRAINING;
            end else begin
              rd_st_d = R_IDLE;
            end
          end
        end
      end
      default: rd_st_d = R_IDLE;
    endcase

    // A draining bank accepts new writes only into slots that have already been fetched.
    din_ready_d = (bank_st_d[wbank_d] == B_EMPTY) ||
                  (bank_st_d[wbank_d] == B_FILLING) ||
                  ((bank_st_d[wbank_d] == B_DRAINING) && (wptr_d < rptr_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st_q    <= '{default: B_EMPTY};
      kmax_q       <= '{default: '0};
      shift_q      <= '{default: '0};
      wbank_q      <= 1'b0;
      wptr_q       <= '0;
      rbank_q      <= 1'b0;
      rptr_q       <= '0;
      rd_st_q      <= R_IDLE;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_re_q    <= '0;
      dout_im_q    <= '0;
      dout_exp_q   <= '0;
    end else begin
      bank_st_q    <= bank_st_d;
      kmax_q       <= kmax_d;
      shift_q      <= shift_d;
      wbank_q      <= wbank_d;
      wptr_q       <= wptr_d;
      rbank_q      <= rbank_d;
      rptr_q       <= rptr_d;
      rd_st_q      <= rd_st_d;
      din_ready_q  <= din_ready_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      dout_re_q    <= dout_re_d;
      dout_im_q    <= dout_im_d;
      dout_exp_q   <= dout_exp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_re_q[wbank_q][wptr_q] <= din_re;
      mem_im_q[wbank_q][wptr_q] <= din_im;
    end
  end

  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign dout_re    = dout_re_q;
  assign dout_im    = dout_im_q;
  assign dout_exp   = dout_exp_q;

endmodule

// File: tb/tb_cbfp_block_ctrl.sv
// Directed bench for cbfp_block_ctrl: hand-computed blocks, streaming, back-pressure
// and asynchronous reset, with a scoreboard of expected output samples.
module tb_cbfp_block_ctrl;

  localparam int IN_W    = 25;
  localparam int OUT_W   = 13;
  localparam int BLK_LEN = 16;
  localparam int EXP_W   = $clog2(IN_W) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic [IN_W-1:0]  din_re = '0;
  logic [IN_W-1:0]  din_im = '0;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic [OUT_W-1:0] dout_re;
  logic [OUT_W-1:0] dout_im;
  logic             dout_last;
  logic [EXP_W-1:0] dout_exp;

  int checkCount = 0;
  int passCount = 0;
  int cycle = 0;
  int stimRe[$], stimIm[$], expRe[$], expIm[$], expExp[$];
  int gotRe[$], gotIm[$], gotLast[$], gotExp[$];
  int readyLowCycles, drvTimeout, lastAcceptCycle;
  int firstValidCycle, firstXferCycle, lastXferCycle;
  int validSeen;

  cbfp_block_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .BLK_LEN(BLK_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .din_valid(din_valid), .din_ready(din_ready), .din_re(din_re), .din_im(din_im),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_re(dout_re), .dout_im(dout_im),
    .dout_last(dout_last), .dout_exp(dout_exp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic clearVectors();
    stimRe.delete(); stimIm.delete(); expRe.delete(); expIm.delete(); expExp.delete();
  endtask

  task automatic addSample(input int re, input int im, input int eRe, input int eIm, input int eExp);
    stimRe.push_back(re); stimIm.push_back(im);
    expRe.push_back(eRe); expIm.push_back(eIm); expExp.push_back(eExp);
  endtask

  function automatic logic readyAt(input int rel, input int sf, input int sl);
    return !(sl > 0 && rel >= sf && rel < sf + sl);
  endfunction

  // Called on a falling edge; a sample transfers on the next rising edge once din_ready is seen.
  task automatic applyStimulus();
    int budget;
    readyLowCycles = 0;
    drvTimeout = 0;
    for (int i = 0; i < stimRe.size(); i++) begin
      din_valid = 1'b1;
      din_re = IN_W'(stimRe[i]);
      din_im = IN_W'(stimIm[i]);
      budget = 0;
      while (!din_ready && budget < 500) begin
        readyLowCycles++;
        budget++;
        @(negedge clk);
      end
      if (!din_ready) begin
        drvTimeout = 1;
        break;
      end
      lastAcceptCycle = cycle;
      @(negedge clk);
    end
    din_valid = 1'b0;
  endtask

  task automatic collectOutputs(input int n, input int sf, input int sl);
    int rel = 0;
    gotRe.delete(); gotIm.delete(); gotLast.delete(); gotExp.delete();
    firstValidCycle = -1; firstXferCycle = -1; lastXferCycle = -1;
    while (gotRe.size() < n && rel < 3000) begin
      @(negedge clk);
      rel++;
      dout_ready = readyAt(rel, sf, sl);
      if (dout_valid && firstValidCycle < 0) firstValidCycle = cycle;
      if (dout_valid && dout_ready) begin
        gotRe.push_back(int'($signed(dout_re)));
        gotIm.push_back(int'($signed(dout_im)));
        gotLast.push_back(int'(dout_last));
        gotExp.push_back(int'(dout_exp));
        if (firstXferCycle < 0) firstXferCycle = cycle;
        lastXferCycle = cycle;
      end
    end
  endtask

  task automatic runStream(input string tag, input int sf, input int sl);
    int n;
    n = stimRe.size();
    fork
      applyStimulus();
      collectOutputs(n, sf, sl);
    join
    checkOutput({tag, "_drv_timeout"}, drvTimeout, 0);
    checkOutput({tag, "_count"}, gotRe.size(), n);
    for (int i = 0; i < n && i < gotRe.size(); i++) begin
      checkOutput($sformatf("%s_re[%0d]", tag, i), gotRe[i], expRe[i]);
      checkOutput($sformatf("%s_im[%0d]", tag, i), gotIm[i], expIm[i]);
      checkOutput($sformatf("%s_last[%0d]", tag, i), gotLast[i], int'((i % BLK_LEN) == BLK_LEN - 1));
      checkOutput($sformatf("%s_exp[%0d]", tag, i), gotExp[i], expExp[i]);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic loadNeg4097Block();
    clearVectors();
    for (int i = 0; i < BLK_LEN; i++) begin
      if (i == 7) addSample(i, -4097, i / 2, -2049, 1);
      else addSample(i, -i, i / 2, -((i + 1) / 2), 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_din_ready", int'(din_ready), 1);
    checkOutput("reset_dout_valid", int'(dout_valid), 0);
    checkOutput("reset_dout_re", int'(dout_re), 0);
    checkOutput("reset_dout_im", int'(dout_im), 0);
    checkOutput("reset_dout_last", int'(dout_last), 0);
    checkOutput("reset_dout_exp", int'(dout_exp), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] all-zero block");
    clearVectors();
    for (int i = 0; i < BLK_LEN; i++) addSample(0, 0, 0, 0, 0);
    runStream("t1", 0, 0);
    checkOutput("t1_latency", firstValidCycle - lastAcceptCycle, 3);

    $display("[TB] full-scale block, shift 12");
    clearVectors();
    for (int i = 0; i < BLK_LEN; i++) begin
      if (i == 3) addSample(32'h0FFFFFF, -16777216, 4095, -4096, 12);
      else addSample(i * 4096 + 7, -(i * 4096) - 1, i, -i - 1, 12);
    end
    runStream("t2", 0, 0);

    $display("[TB] -4096 fits without shift");
    clearVectors();
    for (int i = 0; i < BLK_LEN; i++) begin
      if (i == 7) addSample(i, -4096, i, -4096, 0);
      else addSample(i, -i, i, -i, 0);
    end
    runStream("t3a", 0, 0);

    $display("[TB] -4097 needs shift 1");
    loadNeg4097Block();
    runStream("t3b", 0, 0);

    $display("[TB] four back-to-back blocks");
    clearVectors();
    for (int n = 0; n < 4 * BLK_LEN; n++) addSample(100 + n, -(n + 1), 100 + n, -(n + 1), 0);
    runStream("t4", 0, 0);
    checkOutput("t4_span", lastXferCycle - firstXferCycle, 4 * BLK_LEN - 1);
    checkOutput("t4_din_ready_low", readyLowCycles, 0);

    $display("[TB] back-pressure for 40 cycles");
    clearVectors();
    for (int n = 0; n < 4 * BLK_LEN; n++) addSample(200 + n, n * 3, 200 + n, n * 3, 0);
    runStream("t5", 3, 40);
    checkOutput("t5_din_ready_fell", int'(readyLowCycles > 0), 1);

    $display("[TB] reset mid-block 2");
    dout_ready = 1'b0;
    clearVectors();
    for (int i = 0; i < BLK_LEN; i++) addSample((i == 0) ? 32'h0FFFFFF : i, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) addSample(1000 + i, i, 0, 0, 0);
    applyStimulus();
    checkOutput("t6_pre_drv_timeout", drvTimeout, 0);
    checkOutput("t6_pre_valid", int'(dout_valid), 1);
    checkOutput("t6_pre_exp", int'(dout_exp), 12);
    checkOutput("t6_pre_re", int'($signed(dout_re)), 4095);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", int'(dout_valid), 0);
    checkOutput("t6_rst_re", int'(dout_re), 0);
    checkOutput("t6_rst_im", int'(dout_im), 0);
    checkOutput("t6_rst_last", int'(dout_last), 0);
    checkOutput("t6_rst_exp", int'(dout_exp), 0);
    checkOutput("t6_rst_din_ready", int'(din_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dout_ready = 1'b1;
    validSeen = 0;
    repeat (20) begin
      @(negedge clk);
      if (dout_valid) validSeen++;
    end
    checkOutput("t6_no_stale_output", validSeen, 0);
    loadNeg4097Block();
    runStream("t6", 0, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
